// File: rtl/bcdu_exec_if.sv
// BCDU instruction channel: sequencer-issued instruction, accept handshake, status back.
// Latency: none, wires only.
// Backpressure: issuer holds instr_valid/instr until instr_accept is seen high.
interface bcdu_exec_if #(
    parameter int NUM_FLAGS = 4
);
    logic                 instr_valid;
    logic [15:0]          instr;
    logic                 instr_accept;
    logic [NUM_FLAGS-1:0] flags;
    logic                 busy;

    // Sequencer side
    modport master (
        output instr_valid,
        output instr,
        input  instr_accept,
        input  flags,
        input  busy
    );

    // Execution unit side
    modport slave (
        input  instr_valid,
        input  instr,
        output instr_accept,
        output flags,
        output busy
    );
endinterface

// File: rtl/bcdu_exec.sv
// BCD execution unit: 16 x N_DIGITS packed-BCD regfile, digit-serial ADD/SUB/CMP, 1-cycle CLR/MOV/SHL.
// Latency: single-cycle ops commit on the edge after accept; ADD/SUB/CMP commit N_DIGITS+1 edges after accept.
// Backpressure: accept drops for N_DIGITS+1 cycles during arithmetic. Optional macro BCDU_DIGIT_CHECK_EN adds o_digit_err.
module bcdu_exec #(
    parameter int N_DIGITS  = 4,
    parameter int NUM_FLAGS = 4,
    localparam int W        = 4 * N_DIGITS
) (
    input  logic          i_clk,
    input  logic          i_rst,
    bcdu_exec_if.slave    bus,
    input  logic          i_wr_en,
    input  logic [3:0]    i_wr_addr,
    input  logic [W-1:0]  i_wr_data,
    input  logic [3:0]    i_rd_addr,
    output logic [W-1:0]  o_rd_data
`ifdef BCDU_DIGIT_CHECK_EN
    ,
    output logic          o_digit_err
`endif
);
    localparam int CW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [3:0] OP_CLR = 4'd1;
    localparam logic [3:0] OP_MOV = 4'd2;
    localparam logic [3:0] OP_ADD = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd4;
    localparam logic [3:0] OP_CMP = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;

    typedef enum logic [1:0] {S_IDLE, S_ARITH, S_WB} state_t;

    state_t               state, state_d;
    logic [W-1:0]         regs [16];
    logic [3:0]           op_q, rd_q, link_q;
    logic [W-1:0]         opa_q, opb_q, res_q;
    logic                 carry_q;
    logic [CW-1:0]        cnt_q;
    logic [NUM_FLAGS-1:0] flags_q;

    logic [3:0]   op, r1, r2, r3;
    logic         fire, is_arith, shl_ok;
    logic [W-1:0] src_a, src_b, mov_src, lat_a, lat_b, mov_val;
    logic [W-1:0] shl_cur, shl_res;
    logic [3:0]   shl_ins;
    logic [4:0]   sum5, dif5, adj5;
    logic         sub_need, cout;
    logic [3:0]   dig;

    assign op = bus.instr[15:12];
    assign r1 = bus.instr[11:8];
    assign r2 = bus.instr[7:4];
    assign r3 = bus.instr[3:0];

    assign fire     = bus.instr_valid && (state == S_IDLE);
    assign is_arith = (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP);
    assign shl_ok   = (r2 == 4'hC) || (r2 == 4'hD);

    assign bus.instr_accept = (state == S_IDLE);
    assign bus.busy         = (state != S_IDLE);
    assign bus.flags        = flags_q;
    assign o_rd_data        = regs[i_rd_addr];

    function automatic logic [NUM_FLAGS-1:0] mk_flags(input logic zf, input logic cf,
                                                      input logic tf, input logic ef);
        logic [NUM_FLAGS-1:0] f;
        f    = '0;
        f[0] = zf;
        f[1] = cf;
        f[2] = tf;
        f[3] = ef;
        return f;
    endfunction

`ifdef BCDU_DIGIT_CHECK_EN
    function automatic logic [W-1:0] bcd_sat(input logic [W-1:0] v);
        logic [W-1:0] o;
        o = v;
        for (int i = 0; i < N_DIGITS; i++)
            if (v[4*i +: 4] > 4'd9) o[4*i +: 4] = 4'd9;
        return o;
    endfunction

    function automatic logic has_bad(input logic [W-1:0] v);
        logic b;
        b = 1'b0;
        for (int i = 0; i < N_DIGITS; i++)
            if (v[4*i +: 4] > 4'd9) b = 1'b1;
        return b;
    endfunction

    logic digit_bad;
    assign lat_a   = bcd_sat(src_a);
    assign lat_b   = bcd_sat(src_b);
    assign mov_val = bcd_sat(mov_src);
    assign digit_bad = fire && ((is_arith && (has_bad(src_a) || has_bad(src_b)))
                                || ((op == OP_MOV) && has_bad(mov_src)));

    // Sticky non-BCD operand detector, cleared only by reset
    always_ff @(posedge i_clk) begin
        if (i_rst)          o_digit_err <= 1'b0;
        else if (digit_bad) o_digit_err <= 1'b1;
    end
`else
    assign lat_a   = src_a;
    assign lat_b   = src_b;
    assign mov_val = mov_src;
`endif

    // Operand selection: CMP compares r1 against r2, ADD/SUB combine r2 and r3
    always_comb begin
        src_a   = (op == OP_CMP) ? regs[r1] : regs[r2];
        src_b   = (op == OP_CMP) ? regs[r2] : regs[r3];
        mov_src = regs[r2];
    end

    // Left shift by one digit; imm A re-inserts the link digit, B-F insert zero
    always_comb begin
        shl_cur = regs[r1];
        if (r3 <= 4'd9)       shl_ins = r3;
        else if (r3 == 4'hA)  shl_ins = link_q;
        else                  shl_ins = 4'd0;
        shl_res = {shl_cur[W-5:0], shl_ins};
    end

    // One BCD digit of add or subtract with carry/borrow, LSD of the operand shifters
    always_comb begin
        sum5     = {1'b0, opa_q[3:0]} + {1'b0, opb_q[3:0]} + {4'b0, carry_q};
        sub_need = {1'b0, opa_q[3:0]} < ({1'b0, opb_q[3:0]} + {4'b0, carry_q});
        dif5     = {1'b0, opa_q[3:0]} + (sub_need ? 5'd10 : 5'd0)
                   - {1'b0, opb_q[3:0]} - {4'b0, carry_q};
        adj5     = sum5 - 5'd10;
        dig      = dif5[3:0];
        cout     = sub_need;
        if (op_q == OP_ADD) begin
            cout = (sum5 > 5'd9);
            dig  = cout ? adj5[3:0] : sum5[3:0];
        end
    end

    // Next-state logic for the multi-cycle arithmetic path
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (fire && is_arith) state_d = S_ARITH;
            S_ARITH: if (cnt_q == CW'(N_DIGITS - 1)) state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_d;
    end

    // Regfile, flags and datapath; execution writes follow host writes so they win on collision
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
            flags_q <= '0;
            link_q  <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (i_wr_en) regs[i_wr_addr] <= i_wr_data;
            case (state)
                S_IDLE: begin
                    if (fire) begin
                        case (op)
                            OP_CLR: regs[r1] <= '0;
                            OP_MOV: regs[r1] <= mov_val;
                            OP_SHL: begin
                                if (shl_ok) begin
                                    regs[r1] <= shl_res;
                                    link_q   <= shl_cur[W-1:W-4];
                                    flags_q  <= mk_flags(shl_res == '0, 1'b0,
                                                         shl_cur[W-1:W-4] != 4'd0,
                                                         shl_cur == '0);
                                end
                            end
                            OP_ADD, OP_SUB, OP_CMP: begin
                                op_q    <= op;
                                rd_q    <= r1;
                                opa_q   <= lat_a;
                                opb_q   <= lat_b;
                                res_q   <= '0;
                                carry_q <= 1'b0;
                                cnt_q   <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_ARITH: begin
                    opa_q   <= opa_q >> 4;
                    opb_q   <= opb_q >> 4;
                    res_q   <= {dig, res_q[W-1:4]};
                    carry_q <= cout;
                    cnt_q   <= cnt_q + 1'b1;
                end
                S_WB: begin
                    if (op_q != OP_CMP) regs[rd_q] <= res_q;
                    flags_q <= mk_flags(res_q == '0, carry_q, res_q[W-1:W-4] != 4'd0, 1'b0);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bcdu_exec.sv
// Directed bench for bcdu_exec (N_DIGITS=4): handshake timing, arithmetic, shift, reset abort.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: issue task holds valid until accept is seen, bounded by a cycle budget.
module tb_bcdu_exec;
    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
`ifdef BCDU_DIGIT_CHECK_EN
    logic        digit_err;
`endif
    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bcdu_exec_if #(.NUM_FLAGS(4)) bus ();

    bcdu_exec #(.N_DIGITS(4), .NUM_FLAGS(4)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .bus       (bus),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_addr (rd_addr),
        .o_rd_data (rd_data)
`ifdef BCDU_DIGIT_CHECK_EN
        ,
        .o_digit_err (digit_err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic hw(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [15:0] exp);
        rd_addr = a;
        #1;
        check(tag, {16'h0, rd_data}, {16'h0, exp});
    endtask

    task automatic issue(input logic [15:0] ins);
        int n;
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr       = ins;
        n = 0;
        while (!bus.instr_accept && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("issue_timeout", n, 0);
        @(negedge clk);
        bus.instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("idle_timeout", n, 0);
    endtask

    initial begin
        int lo;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        bus.instr_valid = 1'b0; bus.instr = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_accept", bus.instr_accept, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_flags", bus.flags, 4'h0);
        rd_chk("rst_r5", 4'd5, 16'h0000);
`ifdef BCDU_DIGIT_CHECK_EN
        check("rst_digit_err", digit_err, 0);
`endif

        // ADD r3 = 0123 + 0877, accept low for 5 cycles
        hw(4'd1, 16'h0123);
        hw(4'd2, 16'h0877);
        issue(16'h3312);
        lo = 0;
        while (!bus.instr_accept && lo < 50) begin
            lo++;
            @(negedge clk);
        end
        check("add_accept_low", lo, 5);
        rd_chk("add_r3", 4'd3, 16'h1000);
        check("add_flags", bus.flags, 4'b0100);

        // SUB wraps to tens complement; CMP leaves registers alone
        hw(4'd1, 16'h0003);
        hw(4'd2, 16'h0005);
        issue(16'h4412);
        wait_idle();
        rd_chk("sub_r4", 4'd4, 16'h9998);
        check("sub_flags", bus.flags, 4'b0110);
        issue(16'h5210);
        wait_idle();
        check("cmp_flags", bus.flags, 4'b0000);
        rd_chk("cmp_r2", 4'd2, 16'h0005);

        // SHL with immediate, then link digit insertion
        hw(4'd5, 16'h1234);
        issue(16'h65C7);
        rd_chk("shl_r5", 4'd5, 16'h2347);
        check("shl_flags", bus.flags, 4'b0100);
        hw(4'd6, 16'h0000);
        issue(16'h66DA);
        rd_chk("shl_link_r6", 4'd6, 16'h0001);
        check("shl_link_flags", bus.flags, 4'b1000);

        // ADD overflow drops the carry
        hw(4'd11, 16'h9999);
        hw(4'd12, 16'h0001);
        issue(16'h3ABC);
        wait_idle();
        rd_chk("ovf_r10", 4'd10, 16'h0000);
        check("ovf_flags", bus.flags, 4'b0011);

        // Back-to-back CLR, SHL, MOV, NOP with valid held high
        hw(4'd7, 16'h9999);
        hw(4'd8, 16'h5555);
        @(negedge clk);
        bus.instr_valid = 1'b1; bus.instr = 16'h1700;
        check("b2b_acc_clr", bus.instr_accept, 1);
        @(negedge clk);
        bus.instr = 16'h67C3;
        check("b2b_acc_shl", bus.instr_accept, 1);
        @(negedge clk);
        bus.instr = 16'h2870;
        check("b2b_acc_mov", bus.instr_accept, 1);
        @(negedge clk);
        bus.instr = 16'h0000;
        check("b2b_acc_nop", bus.instr_accept, 1);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        rd_chk("b2b_r7", 4'd7, 16'h0003);
        rd_chk("b2b_r8", 4'd8, 16'h0003);
        check("b2b_flags", bus.flags, 4'b1000);

        // Malformed SHL and undefined opcode act as NOP
        issue(16'h6535);
        issue(16'hF500);
        rd_chk("nop_r5", 4'd5, 16'h2347);
        check("nop_flags", bus.flags, 4'b1000);

        // SHL imm B inserts zero and loads link with the MSD
        issue(16'h65CB);
        rd_chk("shl_b_r5", 4'd5, 16'h3470);
        check("shl_b_flags", bus.flags, 4'b0100);

        // Operand latching and writeback-vs-host collision
        hw(4'd1, 16'h4000);
        hw(4'd2, 16'h0500);
        issue(16'h3912);
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 16'h1111;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (3) @(negedge clk);
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h7777;
        @(negedge clk);
        wr_en = 1'b0;
        wait_idle();
        rd_chk("latch_r9", 4'd9, 16'h4500);
        rd_chk("latch_r1", 4'd1, 16'h1111);

        // Full aliasing r1==r2==r3
        hw(4'd13, 16'h0250);
        issue(16'h3DDD);
        wait_idle();
        rd_chk("alias_r13", 4'd13, 16'h0500);
        check("alias_flags", bus.flags, 4'b0000);

        // Reset during arithmetic aborts without writeback
        hw(4'd1, 16'h0001);
        issue(16'h3312);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_accept", bus.instr_accept, 1);
        check("abort_busy", bus.busy, 0);
        check("abort_flags", bus.flags, 4'h0);
        rd_chk("abort_r3", 4'd3, 16'h0000);
        rd_chk("abort_r1", 4'd1, 16'h0000);
        rd_chk("abort_r9", 4'd9, 16'h0000);

        // Link digit cleared by reset
        issue(16'h66DA);
        rd_chk("link_rst_r6", 4'd6, 16'h0000);
        check("link_rst_flags", bus.flags, 4'b1001);

        // Non-BCD operand digits
        hw(4'd1, 16'h00A0);
        issue(16'h3211);
        wait_idle();
`ifdef BCDU_DIGIT_CHECK_EN
        rd_chk("dchk_r2", 4'd2, 16'h0180);
        check("dchk_err", digit_err, 1);
        hw(4'd3, 16'h0001);
        issue(16'h3433);
        wait_idle();
        rd_chk("dchk_r4", 4'd4, 16'h0002);
        check("dchk_sticky", digit_err, 1);
`else
        rd_chk("raw_r2", 4'd2, 16'h01A0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/bcdu_exec.md
Name: bcdu_exec

Overview:
- BCD execution unit: the responder side of the 16-bit BCDU instruction interface that the digit-level sequencers (divide, multiply, ...) drive.
- Holds a 16-entry register file of N_DIGITS-digit packed BCD words.
- Accepts one instruction per valid/accept handshake, executes it (arithmetic is digit-serial, LSD first) and publishes status flags back to the issuing sequencer.
- A host port gives the stack/display logic direct register read and write access.

Parameters:
- N_DIGITS, 4, digits per register; register width W = 4*N_DIGITS.
- NUM_FLAGS, 4, flag vector width. Fixed order: bit0 ZF, bit1 CF, bit2 TF, bit3 EF.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_instr_valid  in  1  instruction present
- i_instr  in  16  [15:12] op, [11:8] r1, [7:4] r2, [3:0] r3/imm
- o_instr_accept  out  1  unit can take an instruction this cycle
- o_flags  out  NUM_FLAGS  status of last flag-setting instruction
- i_wr_en  in  1  host register write
- i_wr_addr  in  4  host write address
- i_wr_data  in  W  host write data
- i_rd_addr  in  4  host read address
- o_rd_data  out  W  combinational read of regfile[i_rd_addr]
- o_busy  out  1  multi-cycle operation in progress

Behaviour:
- Reset: all registers 0; o_flags 0; link digit 0; state S_IDLE; o_instr_accept=1; o_busy=0.
- Reset mid-operation aborts the operation with no writeback.
- Handshake:
  - An instruction transfers on a cycle where i_instr_valid && o_instr_accept.
  - o_instr_accept = (state==S_IDLE).
  - Valid without accept is ignored; the issuer holds the instruction until accepted.
- Opcodes:
  - 0 NOP: no effect.
  - 1 CLR: reg[r1] <= 0. Flags unchanged.
  - 2 MOV: reg[r1] <= reg[r2]. Flags unchanged.
  - 3 ADD: reg[r1] <= (reg[r2] + reg[r3]) mod 10^N.
  - 4 SUB: reg[r1] <= (reg[r2] - reg[r3]) in tens-complement mod 10^N.
  - 5 CMP: computes reg[r1] - reg[r2]. Flags only, no write.
  - 6 SHL: one-digit left shift of reg[r1]; bits [7:4] must be 4'b1100 or 4'b1101.
  - Opcodes 7-F, and SHL with any other [7:4], execute as NOP.
- SHL detail:
  - imm 0-9: the imm digit is inserted as the new LSD.
  - imm A: the link digit is inserted.
  - imm B-F: 0 is inserted.
  - The shifted-out MSD is stored to the link digit.
  - Flags: ZF = result==0; CF = 0; TF = shifted-out digit!=0; EF = register was 0 before the shift.
- ADD/SUB/CMP flags:
  - ZF = result==0.
  - CF = carry-out (ADD) or borrow (SUB/CMP).
  - TF = result MSD!=0.
  - EF = 0.
- Timing, single-cycle ops (NOP, CLR, MOV, SHL):
  - Register and flags update on the clock edge after acceptance.
  - Accept stays high, so back-to-back issue is allowed.
  - Operands are read from the current regfile, so each instruction sees the previous instruction's result.
- Timing, ADD/SUB/CMP:
  - FSM S_IDLE -> S_ARITH -> S_WB -> S_IDLE.
  - On accept: latch operands into shift registers, clear the carry, digit counter = 0.
  - S_ARITH: one digit per cycle, LSD first, carry/borrow held in a flop, result shifted in at the MSD end; lasts N_DIGITS cycles.
  - S_WB: one cycle; writes the result (not for CMP) and flags.
  - Accept low for N_DIGITS+1 cycles; reaccept on cycle N_DIGITS+2 after acceptance.
  - o_busy = (state!=S_IDLE).
- Host write:
  - Accepted in any cycle.
  - If it targets the same register as an execution writeback in the same cycle, the execution write wins.
  - A host write to an operand register during S_ARITH does not affect the running operation, because operands are latched.
- Wrap-around: ADD overflow drops the carry (CF=1). SUB of a smaller value yields the tens complement with CF=1, e.g. 0003-0005 = 9998.
- Register aliasing (r1==r2==r3) is legal, since operands are latched.

Optional Feature:
- Macro: BCDU_DIGIT_CHECK_EN.
- When defined:
  - Adds output port o_digit_err (1 bit, reset 0).
  - Any ADD/SUB/CMP/MOV operand digit >9 sets o_digit_err sticky until i_rst.
  - The offending digit is treated as 9.
- When undefined:
  - Port absent.
  - Non-BCD digits are processed arithmetically as-is, with no detection.

Test Plan (N_DIGITS=4):
- Host write r1=0123, r2=0877; issue ADD r3,r1,r2 -> accept low 5 cycles; r3=1000; ZF=0, CF=0, TF=1.
- r1=0003, r2=0005; SUB r4,r1,r2 -> r4=9998, CF=1. CMP r2,r1 -> flags ZF=0, CF=0; r2 unchanged.
- r5=1234; SHL r5 imm 7 -> r5=2347, link=1, TF=1. Then r6=0000; SHL r6 imm A -> r6=0001, EF=1.
- Hold i_instr_valid through a CLR, MOV, SHL, NOP sequence -> each accepted on consecutive cycles; results chain correctly.
- Assert i_rst during S_ARITH of ADD -> no writeback; next cycle accept=1, flags=0, regs=0.
- With BCDU_DIGIT_CHECK_EN: r1=00A0, ADD r2,r1,r1 -> o_digit_err=1 and stays high after a later valid ADD.
